// File: rtl/vga_timing_pkg.sv
// VGA 640x480@60 timing constants, coordinate types and small helpers shared by
// the raster generator and downstream pixel-rate stages.
package vga_timing_pkg;

  localparam int COORD_W   = 10;
  localparam int MAX_TOTAL = 1 << COORD_W;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int H_SYNC_START = H_ACTIVE + H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
  localparam int V_SYNC_START = V_ACTIVE + V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

  typedef logic [COORD_W-1:0] coord_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
    logic   hsync;
    logic   vsync;
    logic   video_on;
  } raster_t;

  // Idle raster: origin, both syncs deasserted (high), blanked.
  localparam raster_t RASTER_RST = '{x: '0, y: '0, hsync: 1'b1, vsync: 1'b1, video_on: 1'b0};

  function automatic logic in_span(input coord_t v, input coord_t lo, input coord_t hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/pixel_enable_div.sv
// Divides the board clock down to a one-clock pixel-rate enable (every CLK_DIV clocks).
// Free-running, no backpressure; enable is combinational from the divider count.
module pixel_enable_div #(
  parameter int CLK_DIV = 2
) (
  input  logic clck,
  input  logic reset,
  output logic pix_en
);
  import vga_timing_pkg::*;

  if (CLK_DIV < 1 || CLK_DIV > 15) begin : g_bad_div
    $error("pixel_enable_div: CLK_DIV must be in 1..15");
  end

  localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);

  logic [3:0] div_q;
  logic [3:0] div_d;

  assign pix_en = (div_q == DIV_LAST);

  always_comb begin
    div_d = div_q + 4'd1;
    if (pix_en) begin
      div_d = '0;
    end
  end

  always_ff @(posedge clck or posedge reset) begin
    if (reset) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/vga_raster_gen.sv
// VGA raster timing: h/v counters feed a registered output stage (coords, syncs, video_on).
// Outputs lag the counters by one pixel enable and hold between enables; no backpressure.
module vga_raster_gen #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = vga_timing_pkg::H_ACTIVE,
  parameter int H_FP     = vga_timing_pkg::H_FP,
  parameter int H_SYNC   = vga_timing_pkg::H_SYNC,
  parameter int H_BP     = vga_timing_pkg::H_BP,
  parameter int V_ACTIVE = vga_timing_pkg::V_ACTIVE,
  parameter int V_FP     = vga_timing_pkg::V_FP,
  parameter int V_SYNC   = vga_timing_pkg::V_SYNC,
  parameter int V_BP     = vga_timing_pkg::V_BP
) (
  input  logic       clck,
  input  logic       reset,
  output logic [9:0] x_coords,
  output logic [9:0] y_coords,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       pix_tick,
  output logic       frame_start,
  output logic [7:0] frame_count
);
  import vga_timing_pkg::*;

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOT > MAX_TOTAL || V_TOT > MAX_TOTAL) begin : g_bad_total
    $error("vga_raster_gen: line or frame total exceeds coordinate range");
  end

  localparam coord_t H_LAST   = coord_t'(H_TOT - 1);
  localparam coord_t V_LAST   = coord_t'(V_TOT - 1);
  localparam coord_t H_VIS    = coord_t'(H_ACTIVE);
  localparam coord_t V_VIS    = coord_t'(V_ACTIVE);
  localparam coord_t HS_FIRST = coord_t'(H_ACTIVE + H_FP);
  localparam coord_t HS_LAST  = coord_t'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam coord_t VS_FIRST = coord_t'(V_ACTIVE + V_FP);
  localparam coord_t VS_LAST  = coord_t'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic pix_en;

  pixel_enable_div #(
    .CLK_DIV(CLK_DIV)
  ) u_div (
    .clck  (clck),
    .reset (reset),
    .pix_en(pix_en)
  );

  coord_t     h_q, h_d;
  coord_t     v_q, v_d;
  raster_t    ras_q, ras_d;
  logic       pix_tick_q, pix_tick_d;
  logic       frame_start_q, frame_start_d;
  logic       first_done_q, first_done_d;
  logic [7:0] frame_count_q, frame_count_d;

  // Stage 0: free-running position counters.
  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (pix_en) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + coord_t'(1);
      end else begin
        h_d = h_q + coord_t'(1);
      end
    end
  end

  // Stage 1: every pin-facing signal is decoded from the same counter snapshot.
  always_comb begin
    ras_d         = ras_q;
    pix_tick_d    = pix_en;
    frame_start_d = pix_en && (h_q == '0) && (v_q == '0);
    first_done_d  = first_done_q | frame_start_d;
    frame_count_d = frame_count_q;
    if (pix_en) begin
      ras_d.x        = h_q;
      ras_d.y        = v_q;
      ras_d.hsync    = !in_span(h_q, HS_FIRST, HS_LAST);
      ras_d.vsync    = !in_span(v_q, VS_FIRST, VS_LAST);
      ras_d.video_on = (h_q < H_VIS) && (v_q < V_VIS);
    end
    // The origin load straight after reset opens frame 0; only later origins close a frame.
    if (frame_start_d && first_done_q) begin
      frame_count_d = frame_count_q + 8'd1;
    end
  end

  always_ff @(posedge clck or posedge reset) begin
    if (reset) begin
      h_q           <= '0;
      v_q           <= '0;
      ras_q         <= RASTER_RST;
      pix_tick_q    <= 1'b0;
      frame_start_q <= 1'b0;
      first_done_q  <= 1'b0;
      frame_count_q <= '0;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      ras_q         <= ras_d;
      pix_tick_q    <= pix_tick_d;
      frame_start_q <= frame_start_d;
      first_done_q  <= first_done_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign x_coords    = ras_q.x;
  assign y_coords    = ras_q.y;
  assign hsync       = ras_q.hsync;
  assign vsync       = ras_q.vsync;
  assign video_on    = ras_q.video_on;
  assign pix_tick    = pix_tick_q;
  assign frame_start = frame_start_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_raster_gen.sv
// Scoreboard bench: two reduced-raster instances (CLK_DIV=2 and CLK_DIV=1) checked
// tick-by-tick against an arithmetic model of position, syncs and frame count.
module tb_vga_raster_gen;

  typedef struct {
    longint cyc;
    int     x;
    int     y;
    bit     hs;
    bit     vs;
    bit     von;
    bit     fs;
    int     fc;
  } exp_t;

  // Instance A: CLK_DIV=2, 32x17 raster.
  localparam int A_DIV = 2;
  localparam int A_HA = 20, A_HF = 3, A_HS = 5, A_HB = 4;
  localparam int A_VA = 10, A_VF = 2, A_VS = 2, A_VB = 3;
  localparam int A_HT = A_HA + A_HF + A_HS + A_HB;
  localparam int A_VT = A_VA + A_VF + A_VS + A_VB;
  // Instance B: CLK_DIV=1, 8x6 raster so frame_count wraps quickly.
  localparam int B_DIV = 1;
  localparam int B_HA = 4, B_HF = 1, B_HS = 2, B_HB = 1;
  localparam int B_VA = 3, B_VF = 1, B_VS = 1, B_VB = 1;

  logic       clk;
  logic       rst;
  logic [9:0] xa, ya, xb, yb;
  logic       hsa, vsa, vona, pta, fsa;
  logic       hsb, vsb, vonb, ptb, fsb;
  logic [7:0] fca, fcb;

  int     checks = 0;
  int     passes = 0;
  longint cyc = 0;
  exp_t   qa[$];
  exp_t   qb[$];
  exp_t   rst_rec;
  bit     wrap_b = 0;

  vga_raster_gen #(
    .CLK_DIV(A_DIV), .H_ACTIVE(A_HA), .H_FP(A_HF), .H_SYNC(A_HS), .H_BP(A_HB),
    .V_ACTIVE(A_VA), .V_FP(A_VF), .V_SYNC(A_VS), .V_BP(A_VB)
  ) dut_a (
    .clck(clk), .reset(rst), .x_coords(xa), .y_coords(ya), .hsync(hsa), .vsync(vsa),
    .video_on(vona), .pix_tick(pta), .frame_start(fsa), .frame_count(fca)
  );

  vga_raster_gen #(
    .CLK_DIV(B_DIV), .H_ACTIVE(B_HA), .H_FP(B_HF), .H_SYNC(B_HS), .H_BP(B_HB),
    .V_ACTIVE(B_VA), .V_FP(B_VF), .V_SYNC(B_VS), .V_BP(B_VB)
  ) dut_b (
    .clck(clk), .reset(rst), .x_coords(xb), .y_coords(yb), .hsync(hsb), .vsync(vsb),
    .video_on(vonb), .pix_tick(ptb), .frame_start(fsb), .frame_count(fcb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs for the n-th pixel tick after reset release.
  function automatic exp_t ref_model(int n, int ha, int hf, int hs, int hb,
                                     int va, int vf, int vs, int vb);
    exp_t e;
    int ht = ha + hf + hs + hb;
    int vt = va + vf + vs + vb;
    int ft = ht * vt;
    e.cyc = 0;
    e.x   = n % ht;
    e.y   = (n / ht) % vt;
    e.hs  = !((e.x >= ha + hf) && (e.x < ha + hf + hs));
    e.vs  = !((e.y >= va + vf) && (e.y < va + vf + vs));
    e.von = (e.x < ha) && (e.y < va);
    e.fs  = (n % ft) == 0;
    e.fc  = (n / ft) % 256;
    return e;
  endfunction

  task automatic check_rec(input string name, input exp_t e, input longint now,
                           input int x, input int y, input bit hs, input bit vs,
                           input bit von, input bit fs, input int fc);
    checks++;
    if (e.cyc != now || e.x != x || e.y != y || e.hs != hs || e.vs != vs ||
        e.von != von || e.fs != fs || e.fc != fc) begin
      $display("FAIL %s cyc=%0d got(x=%0d y=%0d hs=%0b vs=%0b von=%0b fs=%0b fc=%0d) exp(cyc=%0d x=%0d y=%0d hs=%0b vs=%0b von=%0b fs=%0b fc=%0d)",
               name, now, x, y, hs, vs, von, fs, fc,
               e.cyc, e.x, e.y, e.hs, e.vs, e.von, e.fs, e.fc);
    end else begin
      passes++;
    end
  endtask

  task automatic check_flag(input string name, input bit got, input bit exp_v);
    checks++;
    if (got !== exp_v) $display("FAIL %s got=%0b exp=%0b", name, got, exp_v);
    else passes++;
  endtask

  task automatic note_fail(input string name);
    checks++;
    $display("FAIL %s cyc=%0d", name, cyc);
  endtask

  // Reference: count clocks since release; every CLK_DIV-th clock is the next tick.
  initial begin
    int rel_a = 0, n_a = 0, rel_b = 0, n_b = 0;
    exp_t e;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        rel_a = 0; n_a = 0; qa.delete();
        rel_b = 0; n_b = 0; qb.delete();
      end else begin
        rel_a++;
        if (rel_a % A_DIV == 0) begin
          e = ref_model(n_a, A_HA, A_HF, A_HS, A_HB, A_VA, A_VF, A_VS, A_VB);
          e.cyc = cyc;
          qa.push_back(e);
          n_a++;
        end
        rel_b++;
        if (rel_b % B_DIV == 0) begin
          e = ref_model(n_b, B_HA, B_HF, B_HS, B_HB, B_VA, B_VF, B_VS, B_VB);
          e.cyc = cyc;
          qb.push_back(e);
          n_b++;
        end
      end
    end
  end

  // Monitor A: compare on each pix_tick; between ticks outputs must hold.
  initial begin
    exp_t la, e;
    la = rst_rec;
    forever begin
      @(negedge clk);
      if (rst) begin
        la = rst_rec;
        qa.delete();
      end else if (pta) begin
        if (qa.size() == 0) note_fail("a_unexpected_tick");
        else begin
          e = qa.pop_front();
          check_rec("a_tick", e, cyc, int'(xa), int'(ya), hsa, vsa, vona, fsa, int'(fca));
          la = e;
          la.fs = 0;
        end
      end else begin
        if (qa.size() != 0 && qa[0].cyc <= cyc) begin
          note_fail("a_missed_tick");
          void'(qa.pop_front());
        end
        e = la;
        e.cyc = cyc;
        check_rec("a_hold", e, cyc, int'(xa), int'(ya), hsa, vsa, vona, fsa, int'(fca));
      end
    end
  end

  // Monitor B: CLK_DIV=1, so after release every clock must carry a tick.
  initial begin
    exp_t lb, e;
    int prev_fc = 0;
    lb = rst_rec;
    forever begin
      @(negedge clk);
      if (rst) begin
        lb = rst_rec;
        qb.delete();
        prev_fc = 0;
      end else if (ptb) begin
        if (qb.size() == 0) note_fail("b_unexpected_tick");
        else begin
          e = qb.pop_front();
          check_rec("b_tick", e, cyc, int'(xb), int'(yb), hsb, vsb, vonb, fsb, int'(fcb));
          lb = e;
          lb.fs = 0;
        end
        if (fsb && fcb == 8'd0 && prev_fc == 255) wrap_b = 1;
        prev_fc = int'(fcb);
      end else begin
        if (qb.size() != 0 && qb[0].cyc <= cyc) begin
          note_fail("b_missed_tick");
          void'(qb.pop_front());
        end
        e = lb;
        e.cyc = cyc;
        check_rec("b_hold", e, cyc, int'(xb), int'(yb), hsb, vsb, vonb, fsb, int'(fcb));
      end
    end
  end

  // Async reset must clear every output before any clock edge.
  task automatic check_reset_now(input string tag);
    exp_t r;
    r = rst_rec;
    r.cyc = cyc;
    check_rec({tag, "_rst_a"}, r, cyc, int'(xa), int'(ya), hsa, vsa, vona, fsa, int'(fca));
    check_flag({tag, "_rst_a_tick"}, pta, 1'b0);
    check_rec({tag, "_rst_b"}, r, cyc, int'(xb), int'(yb), hsb, vsb, vonb, fsb, int'(fcb));
    check_flag({tag, "_rst_b_tick"}, ptb, 1'b0);
  endtask

  initial begin
    int  tx, ty;
    bit  found;
    rst_rec = '{cyc: 0, x: 0, y: 0, hs: 1, vs: 1, von: 0, fs: 0, fc: 0};
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 check_reset_now("init");
    #($urandom_range(1, 7)) rst = 1'b0;

    // Long run: many A frames, >256 B frames (frame_count wrap).
    repeat (13000) @(posedge clk);
    check_flag("b_fc_wrapped", wrap_b, 1'b1);

    // Mid-frame reset at a random visible-ish position of instance A.
    tx = $urandom_range(1, A_HT - 1);
    ty = $urandom_range(1, A_VT - 1);
    found = 0;
    for (int i = 0; i < 3000 && !found; i++) begin
      @(negedge clk);
      if (pta && int'(xa) == tx && int'(ya) == ty) found = 1;
    end
    check_flag("wait_target_pos", found, 1'b1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_reset_now("mid");
    repeat (3) @(posedge clk);
    #($urandom_range(1, 8)) rst = 1'b0;
    repeat (3000) @(posedge clk);

    // Short random reset pulses at random phases.
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #($urandom_range(1, 8)) rst = 1'b1;
      #1 check_reset_now("pulse");
      repeat ($urandom_range(1, 5)) @(posedge clk);
      #($urandom_range(1, 8)) rst = 1'b0;
      repeat ($urandom_range(200, 2000)) @(posedge clk);
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
